// File: rtl/fir_channel_scheduler.sv
// Two-channel scheduler for a shared FIR datapath (coef ROM, sample RAM, MAC).
// Channels are arbitrated round-robin. Each accepted sample is written into its
// channel's RAM bank, then TAPS MAC terms are issued. A done pulse follows after
// MAC_LAT cycles. The RAM is cleared after reset and whenever clear is seen in IDLE.
module fir_channel_scheduler #(
  parameter int unsigned DW      = 8,
  parameter int unsigned TAPS    = 8,
  parameter int unsigned AW      = $clog2(TAPS),
  parameter int unsigned MAC_LAT = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          valid0,
  input  logic [DW-1:0] x0,
  output logic          ready0,
  input  logic          valid1,
  input  logic [DW-1:0] x1,
  output logic          ready1,
  output logic          en,
  output logic          we,
  output logic [AW-1:0] rom_address,
  output logic [AW:0]   ram_address,
  output logic [DW-1:0] x_sel,
  output logic          mac_init,
  output logic          done,
  output logic          done_ch
);

  // The shared counter walks CLEAR addresses, MAC terms and WAIT cycles.
  localparam int unsigned CNT_MAX = (2 * TAPS > MAC_LAT) ? 2 * TAPS : MAC_LAT;
  localparam int unsigned CW      = $clog2(CNT_MAX);
  localparam int unsigned RW      = AW + 1;

  typedef enum logic [2:0] {
    S_INIT,
    S_CLEAR,
    S_IDLE,
    S_WRITE,
    S_MAC,
    S_WAIT
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          g, g_d;
  logic [DW-1:0] x_reg, x_d;
  logic          rr_last, rr_d;
  logic [AW-1:0] wptr   [2];
  logic [AW-1:0] wptr_d [2];
  logic          grant;
  logic          acc0, acc1;

  logic          ready_d, en_d, we_d, mi_d, done_d, done_ch_d;
  logic [AW-1:0] rom_d;
  logic [RW-1:0] ram_d;
  logic [DW-1:0] xs_d;

  assign acc0 = valid0 && ready0;
  assign acc1 = valid1 && ready1;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_INIT;
    end else begin
      state <= state_d;
    end
  end

  // Next-state, arbitration and job bookkeeping.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    g_d       = g;
    x_d       = x_reg;
    rr_d      = rr_last;
    wptr_d    = wptr;
    done_d    = 1'b0;
    done_ch_d = done_ch;
    grant     = 1'b0;
    case (state)
      S_INIT: begin
        state_d = S_CLEAR;
        cnt_d   = '0;
      end
      S_CLEAR: begin
        wptr_d[0] = '0;
        wptr_d[1] = '0;
        if (cnt == CW'(2 * TAPS - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      S_IDLE: begin
        // clear wins over any pending sample; no handshake completes.
        if (clear) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end else if (acc0 || acc1) begin
          grant   = (acc0 && acc1) ? !rr_last : acc1;
          g_d     = grant;
          x_d     = grant ? x1 : x0;
          rr_d    = grant;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        state_d = S_MAC;
        cnt_d   = '0;
      end
      S_MAC: begin
        if (cnt == CW'(TAPS - 1)) begin
          wptr_d[g] = wptr[g] + AW'(1);
          state_d   = S_WAIT;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      S_WAIT: begin
        if (cnt == CW'(MAC_LAT - 1)) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          done_d    = 1'b1;
          done_ch_d = g;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: begin
        state_d = S_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Output values for the upcoming cycle, decoded from the next state.
  always_comb begin
    ready_d = 1'b0;
    en_d    = 1'b0;
    we_d    = 1'b0;
    mi_d    = 1'b0;
    rom_d   = '0;
    ram_d   = '0;
    xs_d    = '0;
    case (state_d)
      S_CLEAR: begin
        en_d  = 1'b1;
        we_d  = 1'b1;
        ram_d = cnt_d[RW-1:0];
      end
      S_IDLE: begin
        ready_d = 1'b1;
      end
      S_WRITE: begin
        en_d  = 1'b1;
        we_d  = 1'b1;
        ram_d = {g_d, wptr_d[g_d]};
        xs_d  = x_d;
      end
      S_MAC: begin
        en_d  = 1'b1;
        rom_d = cnt_d[AW-1:0];
        ram_d = {g_d, AW'(wptr_d[g_d] - cnt_d[AW-1:0])};
        mi_d  = (cnt_d == '0);
      end
      default: begin
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      g           <= 1'b0;
      x_reg       <= '0;
      rr_last     <= 1'b1;
      wptr[0]     <= '0;
      wptr[1]     <= '0;
      ready0      <= 1'b0;
      ready1      <= 1'b0;
      en          <= 1'b0;
      we          <= 1'b0;
      rom_address <= '0;
      ram_address <= '0;
      x_sel       <= '0;
      mac_init    <= 1'b0;
      done        <= 1'b0;
      done_ch     <= 1'b0;
    end else begin
      cnt         <= cnt_d;
      g           <= g_d;
      x_reg       <= x_d;
      rr_last     <= rr_d;
      wptr[0]     <= wptr_d[0];
      wptr[1]     <= wptr_d[1];
      ready0      <= ready_d;
      ready1      <= ready_d;
      en          <= en_d;
      we          <= we_d;
      rom_address <= rom_d;
      ram_address <= ram_d;
      x_sel       <= xs_d;
      mac_init    <= mi_d;
      done        <= done_d;
      done_ch     <= done_ch_d;
    end
  end

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Directed bench for fir_channel_scheduler (default parameters).
module tb_fir_channel_scheduler;

  logic       clock;
  logic       reset;
  logic       clear;
  logic       valid0, valid1;
  logic [7:0] x0, x1;
  logic       ready0, ready1;
  logic       en, we;
  logic [2:0] rom_address;
  logic [3:0] ram_address;
  logic [7:0] x_sel;
  logic       mac_init, done, done_ch;

  int n_tests = 0;
  int n_fail  = 0;
  int jn      = 0;

  typedef struct {
    logic       en;
    logic       we;
    logic       mi;
    logic       dn;
    logic       rdy;
    logic [2:0] rom;
    logic [3:0] ram;
    logic [7:0] xs;
  } vec_t;

  vec_t tab [13];

  fir_channel_scheduler dut (
    .clock       (clock),
    .reset       (reset),
    .clear       (clear),
    .valid0      (valid0),
    .x0          (x0),
    .ready0      (ready0),
    .valid1      (valid1),
    .x1          (x1),
    .ready1      (ready1),
    .en          (en),
    .we          (we),
    .rom_address (rom_address),
    .ram_address (ram_address),
    .x_sel       (x_sel),
    .mac_init    (mac_init),
    .done        (done),
    .done_ch     (done_ch)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic e, input logic w, input logic m, input logic d,
                              input logic r, input logic [2:0] ro, input logic [3:0] ra,
                              input logic [7:0] xs);
    vec_t v;
    v.en = e; v.we = w; v.mi = m; v.dn = d; v.rdy = r; v.rom = ro; v.ram = ra; v.xs = xs;
    return v;
  endfunction

  // Called at the negedge just after reset release: one INIT cycle, then 16 clear writes.
  task automatic init_clear_seq(input string tag);
    check({tag, "_init_en"}, 32'(en), 32'd0);
    check({tag, "_init_done"}, 32'(done), 32'd0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      check($sformatf("%s_clr%0d_en", tag, i), 32'(en), 32'd1);
      check($sformatf("%s_clr%0d_we", tag, i), 32'(we), 32'd1);
      check($sformatf("%s_clr%0d_addr", tag, i), 32'(ram_address), 32'(i));
      check($sformatf("%s_clr%0d_xsel", tag, i), 32'(x_sel), 32'd0);
      check($sformatf("%s_clr%0d_done", tag, i), 32'(done), 32'd0);
    end
    @(negedge clock);
    check({tag, "_idle_rdy0"}, 32'(ready0), 32'd1);
    check({tag, "_idle_rdy1"}, 32'(ready1), 32'd1);
    check({tag, "_idle_en"}, 32'(en), 32'd0);
  endtask

  // Called at an IDLE negedge whose inputs make channel ch the winner at the next edge.
  // Returns at the negedge of the done cycle.
  task automatic job_check(input logic ch, input logic [2:0] slot, input logic [7:0] xv);
    logic [3:0] a0, a1;
    a0 = {ch, slot};
    a1 = {ch, 3'(slot - 3'd1)};
    jn++;
    @(negedge clock);
    check($sformatf("j%0d_wr_we", jn), 32'(we), 32'd1);
    check($sformatf("j%0d_wr_addr", jn), 32'(ram_address), 32'(a0));
    check($sformatf("j%0d_wr_data", jn), 32'(x_sel), 32'(xv));
    check($sformatf("j%0d_busy_rdy", jn), 32'(ready0 | ready1), 32'd0);
    @(negedge clock);
    check($sformatf("j%0d_k0_init", jn), 32'(mac_init), 32'd1);
    check($sformatf("j%0d_k0_ram", jn), 32'(ram_address), 32'(a0));
    @(negedge clock);
    check($sformatf("j%0d_k1_init", jn), 32'(mac_init), 32'd0);
    check($sformatf("j%0d_k1_rom", jn), 32'(rom_address), 32'd1);
    check($sformatf("j%0d_k1_ram", jn), 32'(ram_address), 32'(a1));
    repeat (8) @(negedge clock);
    check($sformatf("j%0d_wait_en", jn), 32'(en), 32'd0);
    check($sformatf("j%0d_wait_done", jn), 32'(done), 32'd0);
    @(negedge clock);
    check($sformatf("j%0d_done", jn), 32'(done), 32'd1);
    check($sformatf("j%0d_done_ch", jn), 32'(done_ch), 32'(ch));
  endtask

  initial begin
    // Expected outputs for a ch0 job with x=5 into slot 0, offsets 1..13 after accept.
    tab[0]  = mk(1, 1, 0, 0, 0, 3'd0, 4'd0, 8'd5);
    tab[1]  = mk(1, 0, 1, 0, 0, 3'd0, 4'd0, 8'd0);
    tab[2]  = mk(1, 0, 0, 0, 0, 3'd1, 4'd7, 8'd0);
    tab[3]  = mk(1, 0, 0, 0, 0, 3'd2, 4'd6, 8'd0);
    tab[4]  = mk(1, 0, 0, 0, 0, 3'd3, 4'd5, 8'd0);
    tab[5]  = mk(1, 0, 0, 0, 0, 3'd4, 4'd4, 8'd0);
    tab[6]  = mk(1, 0, 0, 0, 0, 3'd5, 4'd3, 8'd0);
    tab[7]  = mk(1, 0, 0, 0, 0, 3'd6, 4'd2, 8'd0);
    tab[8]  = mk(1, 0, 0, 0, 0, 3'd7, 4'd1, 8'd0);
    tab[9]  = mk(0, 0, 0, 0, 0, 3'd0, 4'd0, 8'd0);
    tab[10] = mk(0, 0, 0, 0, 0, 3'd0, 4'd0, 8'd0);
    tab[11] = mk(0, 0, 0, 1, 1, 3'd0, 4'd0, 8'd0);
    tab[12] = mk(0, 0, 0, 0, 1, 3'd0, 4'd0, 8'd0);

    reset = 1'b1; clear = 1'b0;
    valid0 = 1'b0; valid1 = 1'b0; x0 = '0; x1 = '0;
    #2 reset = 1'b0;

    // Reset values.
    repeat (3) @(negedge clock);
    check("rst_en", 32'(en), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_rdy0", 32'(ready0), 32'd0);
    check("rst_rdy1", 32'(ready1), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_done_ch", 32'(done_ch), 32'd0);
    check("rst_mac_init", 32'(mac_init), 32'd0);
    check("rst_ram", 32'(ram_address), 32'd0);

    // Release: INIT then CLEAR.
    reset = 1'b1;
    init_clear_seq("t1");

    // Single ch0 sample, full cycle-by-cycle profile.
    valid0 = 1'b1; x0 = 8'd5;
    for (int i = 0; i < 13; i++) begin
      @(negedge clock);
      if (i == 0) valid0 = 1'b0;
      check($sformatf("t2_o%0d_en", i + 1), 32'(en), 32'(tab[i].en));
      check($sformatf("t2_o%0d_we", i + 1), 32'(we), 32'(tab[i].we));
      check($sformatf("t2_o%0d_init", i + 1), 32'(mac_init), 32'(tab[i].mi));
      check($sformatf("t2_o%0d_done", i + 1), 32'(done), 32'(tab[i].dn));
      check($sformatf("t2_o%0d_rdy", i + 1), 32'(ready0), 32'(tab[i].rdy));
      if (tab[i].en) check($sformatf("t2_o%0d_ram", i + 1), 32'(ram_address), 32'(tab[i].ram));
      if (tab[i].we) check($sformatf("t2_o%0d_xsel", i + 1), 32'(x_sel), 32'(tab[i].xs));
      if (tab[i].en && !tab[i].we)
        check($sformatf("t2_o%0d_rom", i + 1), 32'(rom_address), 32'(tab[i].rom));
      if (tab[i].dn) check($sformatf("t2_o%0d_done_ch", i + 1), 32'(done_ch), 32'd0);
    end

    // Reset in the middle of a job: immediate abort, no done, INIT+CLEAR replay.
    valid0 = 1'b1; x0 = 8'd7;
    @(negedge clock);
    valid0 = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    #1;
    check("t6_abort_en", 32'(en), 32'd0);
    check("t6_abort_we", 32'(we), 32'd0);
    check("t6_abort_init", 32'(mac_init), 32'd0);
    check("t6_abort_done", 32'(done), 32'd0);
    check("t6_abort_rdy", 32'(ready0), 32'd0);
    repeat (2) @(negedge clock);
    check("t6_held_done", 32'(done), 32'd0);
    reset = 1'b1;
    init_clear_seq("t6");

    // Both channels valid and held: alternating grants, ch0 first after reset.
    valid0 = 1'b1; valid1 = 1'b1; x0 = 8'h11; x1 = 8'h22;
    job_check(1'b0, 3'd0, 8'h11);
    job_check(1'b1, 3'd0, 8'h22);
    job_check(1'b0, 3'd1, 8'h11);
    job_check(1'b1, 3'd1, 8'h22);
    valid0 = 1'b0; valid1 = 1'b0;

    // clear alongside valid0 in IDLE: no accept, a full clear, pointers back to 0.
    clear = 1'b1; valid0 = 1'b1; x0 = 8'h33;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      clear = 1'b0;
      check($sformatf("t4_clr%0d_we", i), 32'(we), 32'd1);
      check($sformatf("t4_clr%0d_addr", i), 32'(ram_address), 32'(i));
      check($sformatf("t4_clr%0d_xsel", i), 32'(x_sel), 32'd0);
    end
    @(negedge clock);
    check("t4_idle_rdy0", 32'(ready0), 32'd1);
    check("t4_idle_en", 32'(en), 32'd0);
    job_check(1'b0, 3'd0, 8'h33);
    valid0 = 1'b0;

    // Nine ch1 samples: slot wraps 7 -> 0; ch0 bank pointer untouched (it sits at 1).
    valid1 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      x1 = 8'(8'h40 + i);
      job_check(1'b1, 3'(i), 8'(8'h40 + i));
    end
    valid1 = 1'b0;
    valid0 = 1'b1; x0 = 8'h55;
    job_check(1'b0, 3'd1, 8'h55);
    valid0 = 1'b0;

    @(negedge clock);
    check("end_done_pulse", 32'(done), 32'd0);
    check("end_idle_en", 32'(en), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
